// File: rtl/decode_redirect_unit_pkg.sv
// MIPS decode constants, IF/ID FSM states and the branch-op decode helper shared by the decode/redirect slice.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6
  } br_op_t;

  // REGIMM rt codes other than bltz/bgez are not conditional branches here.
  function automatic br_op_t decode_branch(input logic [31:0] instr);
    br_op_t op;
    op = BR_NONE;
    case (instr[31:26])
      OP_BEQ:  op = BR_BEQ;
      OP_BNE:  op = BR_BNE;
      OP_BLEZ: op = BR_BLEZ;
      OP_BGTZ: op = BR_BGTZ;
      OP_REGIMM: begin
        if (instr[20:16] == RT_BLTZ)
          op = BR_BLTZ;
        else if (instr[20:16] == RT_BGEZ)
          op = BR_BGEZ;
      end
      default: op = BR_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_redirect_unit_if.sv
// Fetch / register-file / pipeline-side signal bundle of the decode redirect unit.
interface decode_redirect_unit_if;

  logic [31:0] IfPcPlus4;
  logic [31:0] IfInstr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        ExRegWrite;
  logic [4:0]  ExDstReg;
  logic        MemMemRead;
  logic [4:0]  MemDstReg;

  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic        PcSrc;
  logic        Jump;
  logic        JumpRegister;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JumpRegisterTarget;
  logic [31:0] IdInstr;
  logic [31:0] IdPcPlus4;
  logic        IdValid;

  modport master (
    output IfPcPlus4, IfInstr, RsData, RtData,
    output ExRegWrite, ExDstReg, MemMemRead, MemDstReg,
    input  RsAddr, RtAddr, PcSrc, Jump, JumpRegister,
    input  BranchTarget, JumpTarget, JumpRegisterTarget,
    input  IdInstr, IdPcPlus4, IdValid
  );

  modport slave (
    input  IfPcPlus4, IfInstr, RsData, RtData,
    input  ExRegWrite, ExDstReg, MemMemRead, MemDstReg,
    output RsAddr, RtAddr, PcSrc, Jump, JumpRegister,
    output BranchTarget, JumpTarget, JumpRegisterTarget,
    output IdInstr, IdPcPlus4, IdValid
  );

endinterface

// File: rtl/decode_redirect_unit_branch_compare.sv
// Resolves a decoded conditional branch against register operands; purely combinational.
module branch_compare
  import mips_pkg::*;
(
  input  br_op_t      op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        taken
);

  logic rs_zero;
  logic rs_neg;
  logic rs_eq_rt;

  assign rs_zero  = (rs_data == 32'd0);
  assign rs_neg   = rs_data[31];
  assign rs_eq_rt = (rs_data == rt_data);

  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = rs_eq_rt;
      BR_BNE:  taken = !rs_eq_rt;
      BR_BLEZ: taken = rs_neg || rs_zero;
      BR_BGTZ: taken = !rs_neg && !rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_redirect_unit.sv
// IF/ID register plus ID-stage branch/jump resolution and fetch redirect; hazards stall by re-fetching IdPcPlus4.
// DELAY_SLOT_EN: when defined, the instruction fetched alongside a resolved redirect is kept as a delay slot.
module decode_redirect_unit
  import mips_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  decode_redirect_unit_if.slave bus
);

  logic [31:0] id_instr_q;
  logic [31:0] id_pc4_q;
  logic        id_valid_q;
  fsm_state_t  state_q;
  fsm_state_t  state_d;
  logic        if_id_load;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] br_offset;
  br_op_t      br_op;
  logic        br_taken;
  logic        is_branch;
  logic        is_jump;
  logic        is_jr;
  logic        uses_rs;
  logic        uses_rt;
  logic        stall;
  logic        redirect;

  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic       ex_we,
                                      input logic [4:0] ex_dst,
                                      input logic       mem_rd,
                                      input logic [4:0] mem_dst);
    return (src != 5'd0) && ((ex_we && (src == ex_dst)) || (mem_rd && (src == mem_dst)));
  endfunction

  assign opcode    = id_instr_q[31:26];
  assign funct     = id_instr_q[5:0];
  assign rs_addr   = id_instr_q[25:21];
  assign rt_addr   = id_instr_q[20:16];
  assign br_offset = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};

  assign br_op     = decode_branch(id_instr_q);
  assign is_branch = (br_op != BR_NONE);
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_jr     = (opcode == OP_SPECIAL) && (funct == FUNCT_JR);
  assign uses_rs   = is_branch || is_jr;
  assign uses_rt   = (br_op == BR_BEQ) || (br_op == BR_BNE);

  branch_compare u_branch_compare (
    .op      (br_op),
    .rs_data (bus.RsData),
    .rt_data (bus.RtData),
    .taken   (br_taken)
  );

  // j/jal carry no register sources, so they can never stall.
  assign stall = id_valid_q &&
                 ((uses_rs && src_hazard(rs_addr, bus.ExRegWrite, bus.ExDstReg,
                                         bus.MemMemRead, bus.MemDstReg)) ||
                  (uses_rt && src_hazard(rt_addr, bus.ExRegWrite, bus.ExDstReg,
                                         bus.MemMemRead, bus.MemDstReg)));

  assign redirect = id_valid_q && !stall && (br_taken || is_jump || is_jr);

  always_comb begin
    state_d    = state_q;
    if_id_load = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stall)
          state_d = ST_HOLD;
        else
          if_id_load = 1'b1;
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d    = ST_RUN;
          if_id_load = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      id_instr_q <= NOP_INSTR;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (if_id_load) begin
        id_pc4_q <= bus.IfPcPlus4;
        if (redirect) begin
`ifdef DELAY_SLOT_EN
          id_instr_q <= bus.IfInstr;
          id_valid_q <= 1'b1;
`else
          id_instr_q <= NOP_INSTR;
          id_valid_q <= 1'b0;
`endif
        end else begin
          id_instr_q <= bus.IfInstr;
          id_valid_q <= 1'b1;
        end
      end
    end
  end

  // A stall borrows the branch path to re-fetch the instruction now in IF.
  assign bus.PcSrc        = !Reset && (stall || (id_valid_q && br_taken));
  assign bus.Jump         = !Reset && !stall && id_valid_q && is_jump;
  assign bus.JumpRegister = !Reset && !stall && id_valid_q && is_jr;
  assign bus.IdValid      = !Reset && !stall && id_valid_q;

  assign bus.BranchTarget       = stall ? id_pc4_q : (id_pc4_q + br_offset);
  assign bus.JumpTarget         = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
  assign bus.JumpRegisterTarget = bus.RsData;

  assign bus.RsAddr    = rs_addr;
  assign bus.RtAddr    = rt_addr;
  assign bus.IdInstr   = id_instr_q;
  assign bus.IdPcPlus4 = id_pc4_q;

endmodule

// File: tb/tb_decode_redirect_unit.sv
// Table-driven and sequence checks of decode_redirect_unit through an expected-result scoreboard.
module tb_decode_redirect_unit;

  logic Clk;
  logic Reset;

  decode_redirect_unit_if bus();

  decode_redirect_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        ex_we;
    logic [4:0]  ex_dst;
    logic        mem_rd;
    logic [4:0]  mem_dst;
    logic        pcsrc;
    logic        jump;
    logic        jreg;
    logic        valid;
    logic        chk_bt;
    logic [31:0] bt;
    logic        chk_jt;
    logic [31:0] jt;
  } vec_t;

  typedef struct {
    logic        pcsrc;
    logic        jump;
    logic        jreg;
    logic        valid;
    logic        chk_bt;
    logic [31:0] bt;
    logic        chk_jt;
    logic [31:0] jt;
    logic [31:0] jrt;
    logic [4:0]  rsaddr;
    logic [4:0]  rtaddr;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic [31:0] pc4, instr, rs, rt,
                              input logic ex_we, input logic [4:0] ex_dst,
                              input logic mem_rd, input logic [4:0] mem_dst,
                              input logic pcsrc, jump, jreg, valid,
                              input logic chk_bt, input logic [31:0] bt,
                              input logic chk_jt, input logic [31:0] jt);
    vec_t v;
    v.pc4 = pc4; v.instr = instr; v.rs = rs; v.rt = rt;
    v.ex_we = ex_we; v.ex_dst = ex_dst; v.mem_rd = mem_rd; v.mem_dst = mem_dst;
    v.pcsrc = pcsrc; v.jump = jump; v.jreg = jreg; v.valid = valid;
    v.chk_bt = chk_bt; v.bt = bt; v.chk_jt = chk_jt; v.jt = jt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic pcsrc, jump, jreg, valid,
                          input logic chk_bt, input logic [31:0] bt,
                          input logic chk_jt, input logic [31:0] jt,
                          input logic [31:0] jrt, instr, pc4);
    exp_t e;
    e.pcsrc = pcsrc; e.jump = jump; e.jreg = jreg; e.valid = valid;
    e.chk_bt = chk_bt; e.bt = bt; e.chk_jt = chk_jt; e.jt = jt;
    e.jrt = jrt; e.instr = instr; e.pc4 = pc4;
    e.rsaddr = instr[25:21];
    e.rtaddr = instr[20:16];
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got no expectation", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".PcSrc"},        {31'd0, bus.PcSrc},        {31'd0, e.pcsrc});
      chk({tag, ".Jump"},         {31'd0, bus.Jump},         {31'd0, e.jump});
      chk({tag, ".JumpRegister"}, {31'd0, bus.JumpRegister}, {31'd0, e.jreg});
      chk({tag, ".IdValid"},      {31'd0, bus.IdValid},      {31'd0, e.valid});
      if (e.chk_bt) chk({tag, ".BranchTarget"}, bus.BranchTarget, e.bt);
      if (e.chk_jt) chk({tag, ".JumpTarget"},   bus.JumpTarget,   e.jt);
      chk({tag, ".JumpRegisterTarget"}, bus.JumpRegisterTarget, e.jrt);
      chk({tag, ".RsAddr"},    {27'd0, bus.RsAddr}, {27'd0, e.rsaddr});
      chk({tag, ".RtAddr"},    {27'd0, bus.RtAddr}, {27'd0, e.rtaddr});
      chk({tag, ".IdInstr"},   bus.IdInstr,   e.instr);
      chk({tag, ".IdPcPlus4"}, bus.IdPcPlus4, e.pc4);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] rs, rt, input logic ex_we, input logic [4:0] ex_dst,
                         input logic mem_rd, input logic [4:0] mem_dst);
    bus.RsData = rs; bus.RtData = rt;
    bus.ExRegWrite = ex_we; bus.ExDstReg = ex_dst;
    bus.MemMemRead = mem_rd; bus.MemDstReg = mem_dst;
  endtask

  task automatic set_if(input logic [31:0] pc4, instr);
    bus.IfPcPlus4 = pc4;
    bus.IfInstr   = instr;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    set_ops(0, 0, 0, 0, 0, 0);
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back(mk(32'h10, 32'h11090003, 7, 7, 0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h1C, 0, 0));
    vecs.push_back(mk(32'h10, 32'h15090003, 7, 7, 0, 0, 0, 0,  0, 0, 0, 1, 1, 32'h1C, 0, 0));
    vecs.push_back(mk(32'h10, 32'h15090003, 7, 8, 0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h1C, 0, 0));
    vecs.push_back(mk(32'h40000010, 32'h08000100, 0, 0, 1, 8, 0, 0,  0, 1, 0, 1, 0, 0, 1, 32'h40000400));
    vecs.push_back(mk(32'h40000010, 32'h0A100100, 0, 0, 1, 16, 1, 16, 0, 1, 0, 1, 0, 0, 1, 32'h48400400));
    vecs.push_back(mk(32'h40000010, 32'h0C000100, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 1, 32'h40000400));
    vecs.push_back(mk(32'h100, 32'h1800FFFF, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 32'hFC, 0, 0));
    vecs.push_back(mk(32'h20, 32'h1D000002, 5, 0, 1, 9, 0, 8,  1, 0, 0, 1, 1, 32'h28, 0, 0));
    vecs.push_back(mk(32'h20, 32'h1D000002, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h28, 0, 0));
    vecs.push_back(mk(32'h40, 32'h05000004, 32'h80000000, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h50, 0, 0));
    vecs.push_back(mk(32'h40, 32'h05010004, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h50, 0, 0));
    vecs.push_back(mk(32'h40, 32'h05010004, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h50, 0, 0));
    vecs.push_back(mk(32'h10, 32'h11090003, 7, 7, 0, 0, 1, 9,  1, 0, 0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(mk(32'h10, 32'h11090003, 7, 7, 1, 8, 0, 0,  1, 0, 0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(mk(32'h24, 32'h01000008, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(32'h24, 32'h01000008, 32'h1234, 0, 0, 0, 1, 8, 1, 0, 0, 0, 1, 32'h24, 0, 0));
    vecs.push_back(mk(32'h30, 32'hAD090000, 3, 3, 1, 8, 1, 9,  0, 0, 0, 1, 0, 0, 0, 0));

    // Reset state, with reset held across an edge.
    Reset = 1'b1;
    set_if(32'h0, 32'h0);
    set_ops(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    push_exp(0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    #2 compare_out("reset");
    Reset = 1'b0;

    // First load after reset.
    set_if(32'h4, 32'h20080005);
    tick();
    push_exp(0, 0, 0, 1, 1, 32'h18, 1, 32'h0200014, 32'h0, 32'h20080005, 32'h4);
    #2 compare_out("addi_load");

    foreach (vecs[i]) begin
      do_reset();
      set_if(vecs[i].pc4, vecs[i].instr);
      tick();
      set_ops(vecs[i].rs, vecs[i].rt, vecs[i].ex_we, vecs[i].ex_dst,
              vecs[i].mem_rd, vecs[i].mem_dst);
      push_exp(vecs[i].pcsrc, vecs[i].jump, vecs[i].jreg, vecs[i].valid,
               vecs[i].chk_bt, vecs[i].bt, vecs[i].chk_jt, vecs[i].jt,
               vecs[i].rs, vecs[i].instr, vecs[i].pc4);
      #2 compare_out($sformatf("vec%0d", i));
    end

    // Taken beq followed by its delay-slot instruction.
    do_reset();
    set_if(32'h10, 32'h11090003);
    tick();
    set_ops(7, 7, 0, 0, 0, 0);
    set_if(32'h14, 32'h01095020);
    push_exp(1, 0, 0, 1, 1, 32'h1C, 0, 0, 32'd7, 32'h11090003, 32'h10);
    #2 compare_out("beq_taken");
    tick();
    set_ops(0, 0, 0, 0, 0, 0);
    set_if(32'h20, 32'h20080005);
`ifdef DELAY_SLOT_EN
    push_exp(0, 0, 0, 1, 1, 32'h14094, 0, 0, 32'd0, 32'h01095020, 32'h14);
`else
    push_exp(0, 0, 0, 0, 1, 32'h14, 1, 32'h0, 32'd0, 32'h00000000, 32'h14);
`endif
    #2 compare_out("beq_slot");
    tick();
    push_exp(0, 0, 0, 1, 1, 32'h34, 0, 0, 32'd0, 32'h20080005, 32'h20);
    #2 compare_out("beq_target");

    // jr with an EX-stage producer: stall, hold, then resolve.
    do_reset();
    set_if(32'h24, 32'h01000008);
    tick();
    set_ops(32'h55, 0, 1, 8, 0, 0);
    set_if(32'h28, 32'h20090001);
    push_exp(1, 0, 0, 0, 1, 32'h24, 0, 0, 32'h55, 32'h01000008, 32'h24);
    #2 compare_out("jr_stall");
    tick();
    push_exp(1, 0, 0, 0, 1, 32'h24, 0, 0, 32'h55, 32'h01000008, 32'h24);
    #2 compare_out("jr_hold");
    set_ops(32'h200, 0, 0, 8, 0, 0);
    push_exp(0, 0, 1, 1, 1, 32'h44, 1, 32'h04000020, 32'h200, 32'h01000008, 32'h24);
    #2 compare_out("jr_resolve");

    // Load producer: stalls while in EX and again while in MEM.
    do_reset();
    set_if(32'h10, 32'h11090003);
    tick();
    set_ops(3, 3, 1, 9, 0, 0);
    set_if(32'h14, 32'h20080005);
    push_exp(1, 0, 0, 0, 1, 32'h10, 0, 0, 32'd3, 32'h11090003, 32'h10);
    #2 compare_out("load_ex");
    tick();
    set_ops(3, 3, 0, 0, 1, 9);
    push_exp(1, 0, 0, 0, 1, 32'h10, 0, 0, 32'd3, 32'h11090003, 32'h10);
    #2 compare_out("load_mem");
    tick();
    set_ops(3, 3, 0, 0, 0, 9);
    push_exp(1, 0, 0, 1, 1, 32'h1C, 0, 0, 32'd3, 32'h11090003, 32'h10);
    #2 compare_out("load_done");

    // Reset arriving while a stall is active.
    do_reset();
    set_if(32'h24, 32'h01000008);
    tick();
    set_ops(32'h77, 0, 1, 8, 0, 0);
    #2;
    chk("mid_stall.PcSrc_before", {31'd0, bus.PcSrc}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("mid_stall.PcSrc",        {31'd0, bus.PcSrc},        32'd0);
    chk("mid_stall.JumpRegister", {31'd0, bus.JumpRegister}, 32'd0);
    chk("mid_stall.IdValid",      {31'd0, bus.IdValid},      32'd0);
    tick();
    push_exp(0, 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h77, 32'h0, 32'h0);
    #2 compare_out("mid_stall_cleared");
    Reset = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0);
    set_if(32'h4, 32'h20080005);
    tick();
    push_exp(0, 0, 0, 1, 1, 32'h18, 1, 32'h0200014, 32'h0, 32'h20080005, 32'h4);
    #2 compare_out("after_reset_run");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_redirect_unit.md
# decode_redirect_unit

Decode-side counterpart of the instruction fetch stage. Holds the IF/ID pipeline register, decodes branches and jumps, resolves their conditions in ID, and drives the fetch stage's redirect inputs and target addresses. Detects operand hazards on branch/jr sources and stalls by re-fetching, so the fetch PC needs no enable. Sits between fetch and the register file / ID/EX register.

## Interface
- Parameters: none (widths fixed at 32-bit MIPS).
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- IfPcPlus4  in  32  PC+4 of the instruction being fetched (fetch `pc_out`)
- IfInstr  in  32  fetched instruction (fetch `instr_out`)
- RsData / RtData  in  32 each  register-file read data for RsAddr / RtAddr
- ExRegWrite  in  1;  ExDstReg  in  5  destination of the instruction in EX
- MemMemRead  in  1;  MemDstReg  in  5  load in MEM and its destination
- RsAddr / RtAddr  out  5 each  IdInstr[25:21] / IdInstr[20:16]
- PcSrc  out  1  to fetch `pc_in` (selects BranchTarget)
- Jump  out  1;  JumpRegister  out  1  to fetch selects
- BranchTarget / JumpTarget / JumpRegisterTarget  out  32 each
- IdInstr  out  32;  IdPcPlus4  out  32;  IdValid  out  1  to ID/EX

## Operation
- IF/ID register: IdInstr, IdPcPlus4, valid bit. Reset → IdInstr=0x00000000 (NOP), IdPcPlus4=0, valid=0.
- Decoded ops: beq(000100), bne(000101), blez(000110), bgtz(000111), bltz/bgez(000001, rt=0/1), j(000010), jal(000011), jr(opcode 0, funct 001000). All others: no redirect.
- BranchTarget = IdPcPlus4 + (sext(imm16) << 2), mod 2^32; JumpTarget = {IdPcPlus4[31:28], IdInstr[25:0], 2'b00}; JumpRegisterTarget = RsData. Targets always driven from the current IdInstr.
- Conditions: signed compare of RsData (vs RtData for beq/bne, vs 0 otherwise).
- Hazard: branch uses rs (beq/bne also rt), jr uses rs. Stall if a used source ≠ 0 and equals ExDstReg with ExRegWrite, or equals MemDstReg with MemMemRead. j/jal never stall.
- FSM: RUN, HOLD. RUN: IF/ID loads IfInstr/IfPcPlus4, valid=1. RUN→HOLD when stall; HOLD→RUN when stall clears.
- Stall (combinational, any state): PcSrc=1, BranchTarget=IdPcPlus4 (re-fetch instruction currently in IF), Jump=JumpRegister=0, IF/ID holds, IdValid=0 (bubble to EX).
- Resolved redirect: exactly one of PcSrc / Jump / JumpRegister asserted, gated by valid. Next IF/ID load per flush rule (Configuration).
- Outputs IdValid, PcSrc, Jump, JumpRegister forced 0 while Reset high.

## Timing
- IF/ID capture: 1 cycle. Decode, compare, hazard, redirect: combinational from IF/ID regs (0 cycles).
- Taken branch/jump in ID at cycle n → fetch PC = target after edge n; 1-cycle penalty (0 with delay slot).
- Hazard on EX producer: 1 stall cycle; load in EX: 2 stall cycles (EX then MEM).
- Reset mid-stall: FSM → RUN, IF/ID cleared, no redirect issued that cycle.
- Redirect and stall never both effective: stall wins.

## Configuration
- DELAY_SLOT_EN defined: instruction in IF when a redirect resolves (at IdPcPlus4) loads into IF/ID as valid (MIPS delay slot).
- Undefined: that instruction is squashed; IF/ID loads NOP with valid=0.

## Structure
- Shared package mips_pkg: opcode/funct/rt-code constants, NOP constant, 2-state FSM enum.
- One sub-module branch_compare: op + RsData/RtData → taken bit.

## Test plan
- Reset, then IfPcPlus4=0x4, IfInstr=0x20080005 → next cycle IdValid=1, IdInstr=0x20080005, PcSrc=Jump=JumpRegister=0.
- IdPcPlus4=0x10, IdInstr=0x11090003 (beq $8,$9), RsData=RtData=7 → PcSrc=1, BranchTarget=0x1C; next cycle IdValid=0 (no DELAY_SLOT_EN) or delay-slot instruction valid (with).
- Same with 0x15090003 (bne), RsData=RtData → PcSrc=0, BranchTarget=0x1C.
- IdPcPlus4=0x40000010, IdInstr=0x08000100 (j) → Jump=1, JumpTarget=0x40000400, no stall even with ExDstReg matching.
- IdInstr=0x01000008 (jr $8), ExRegWrite=1, ExDstReg=8 → PcSrc=1, BranchTarget=IdPcPlus4, IdValid=0, IF/ID held; next cycle ExRegWrite=0, RsData=0x200 → JumpRegister=1, JumpRegisterTarget=0x200.
- IdPcPlus4=0x100, IdInstr=0x1800FFFF (blez $0,-1), ExRegWrite=1, ExDstReg=0 → no stall, PcSrc=1, BranchTarget=0xFC.
